// File: rtl/camera_capture_sequencer.sv
// Per-command capture sequencer: presence check, trigger, frame supervision, line count and error report.
// Build option: define CAM_RESET_PULSE_EN to pulse the selected camera's reset before each trigger.
module camera_capture_sequencer #(
  parameter int unsigned TRIG_CYCLES    = 16,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000,
  parameter int unsigned RESET_CYCLES   = 64
) (
  input  logic        sysClk,
  input  logic        hard_reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_cam_id,
  input  logic [10:0] cmd_lines,
  input  logic [1:0]  cam_present,
  input  logic        fv_0,
  input  logic        fv_1,
  input  logic        lv_0,
  input  logic        lv_1,
  output logic        trigger_0,
  output logic        trigger_1,
  output logic        reset_0,
  output logic        reset_1,
  output logic        cam_sel,
  output logic        capture_active,
  output logic [10:0] line_count,
  output logic        camera_id_error_flag,
  output logic        camera_timeout_error_flag,
  output logic        image_capture_failure_flag,
  output logic        camera_not_detected_flag,
  output logic        error_flag_valid
);

  localparam logic [2:0] S_IDLE    = 3'd0;
`ifdef CAM_RESET_PULSE_EN
  localparam logic [2:0] S_CRST    = 3'd1;
`endif
  localparam logic [2:0] S_TRIG    = 3'd2;
  localparam logic [2:0] S_WAIT_FV = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_REPORT  = 3'd5;

  // One shared counter times the reset pulse, the trigger pulse and both timeouts.
  localparam int unsigned TIMEOUT_INT = 32'(TIMEOUT_CYCLES);
  localparam int unsigned MAX_PULSE   = (TRIG_CYCLES > RESET_CYCLES) ? TRIG_CYCLES : RESET_CYCLES;
  localparam int unsigned CNT_MAX     = (MAX_PULSE > TIMEOUT_INT) ? MAX_PULSE : TIMEOUT_INT;
  localparam int unsigned CW          = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TRIG_LAST    = CW'(TRIG_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_INT - 1);
`ifdef CAM_RESET_PULSE_EN
  localparam logic [CW-1:0] RESET_LAST   = CW'(RESET_CYCLES - 1);
`endif
  localparam logic [10:0] LINE_MAX = 11'h7FF;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cam_sel_q, cam_sel_d;
  logic [10:0]   lines_q, lines_d;
  logic [10:0]   line_count_q, line_count_d;
  logic          id_err_q, id_err_d;
  logic          timeout_err_q, timeout_err_d;
  logic          fail_q, fail_d;
  logic          not_det_q, not_det_d;
  logic          efv_q, efv_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          active_q, active_d;
  logic [1:0]    trigger_q, trigger_d;
  logic [1:0]    fv_q, lv_q;
  logic [1:0]    fv_s, lv_s;
  logic          accept_s, fv_rise_s, fv_fall_s, lv_rise_s, xt_rise_s;

  assign fv_s      = {fv_1, fv_0};
  assign lv_s      = {lv_1, lv_0};
  assign accept_s  = cmd_valid & cmd_ready_q;
  assign fv_rise_s = fv_s[cam_sel_q] & ~fv_q[cam_sel_q];
  assign fv_fall_s = ~fv_s[cam_sel_q] & fv_q[cam_sel_q];
  assign lv_rise_s = lv_s[cam_sel_q] & ~lv_q[cam_sel_q];
  assign xt_rise_s = fv_s[~cam_sel_q] & ~fv_q[~cam_sel_q];

  // Next-state, counter, flag and registered-output computation.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cam_sel_d     = cam_sel_q;
    lines_d       = lines_q;
    line_count_d  = line_count_q;
    id_err_d      = id_err_q;
    timeout_err_d = timeout_err_q;
    fail_d        = fail_q;
    not_det_d     = not_det_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          cam_sel_d     = cmd_cam_id;
          lines_d       = cmd_lines;
          line_count_d  = 11'd0;
          id_err_d      = 1'b0;
          timeout_err_d = 1'b0;
          fail_d        = 1'b0;
          cnt_d         = {CW{1'b0}};
          if (!cam_present[cmd_cam_id]) begin
            not_det_d = 1'b1;
            state_d   = S_REPORT;
          end else begin
            not_det_d = 1'b0;
`ifdef CAM_RESET_PULSE_EN
            state_d   = S_CRST;
`else
            state_d   = S_TRIG;
`endif
          end
        end else begin
          state_d = S_IDLE;
        end
      end
`ifdef CAM_RESET_PULSE_EN
      S_CRST: begin
        if (cnt_q == RESET_LAST) begin
          cnt_d   = {CW{1'b0}};
          state_d = S_TRIG;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      S_TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          cnt_d   = {CW{1'b0}};
          state_d = S_WAIT_FV;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_FV: begin
        // A frame start beats a timeout landing in the same cycle.
        if (fv_rise_s) begin
          cnt_d   = {CW{1'b0}};
          state_d = S_CAPTURE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_REPORT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CAPTURE: begin
        if (xt_rise_s) begin
          id_err_d = 1'b1;
        end else begin
          id_err_d = id_err_q;
        end
        if (fv_fall_s) begin
          state_d = S_REPORT;
          fail_d  = (line_count_q != lines_q) ? 1'b1 : fail_q;
        end else begin
          if (lv_rise_s && fv_s[cam_sel_q] && (line_count_q != LINE_MAX)) begin
            line_count_d = line_count_q + 11'd1;
          end else begin
            line_count_d = line_count_q;
          end
          if (cnt_q == TIMEOUT_LAST) begin
            fail_d  = 1'b1;
            state_d = S_REPORT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_REPORT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    efv_d        = (state_d == S_REPORT);
    cmd_ready_d  = (state_d == S_IDLE);
    active_d     = (state_d != S_IDLE) && (state_d != S_REPORT);
    trigger_d[0] = (state_d == S_TRIG) && !cam_sel_d;
    trigger_d[1] = (state_d == S_TRIG) && cam_sel_d;
  end

  // State, datapath and output registers.
  always_ff @(posedge sysClk or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= {CW{1'b0}};
      cam_sel_q     <= 1'b0;
      lines_q       <= 11'd0;
      line_count_q  <= 11'd0;
      id_err_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      fail_q        <= 1'b0;
      not_det_q     <= 1'b0;
      efv_q         <= 1'b0;
      cmd_ready_q   <= 1'b1;
      active_q      <= 1'b0;
      trigger_q     <= 2'b00;
      fv_q          <= 2'b00;
      lv_q          <= 2'b00;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cam_sel_q     <= cam_sel_d;
      lines_q       <= lines_d;
      line_count_q  <= line_count_d;
      id_err_q      <= id_err_d;
      timeout_err_q <= timeout_err_d;
      fail_q        <= fail_d;
      not_det_q     <= not_det_d;
      efv_q         <= efv_d;
      cmd_ready_q   <= cmd_ready_d;
      active_q      <= active_d;
      trigger_q     <= trigger_d;
      fv_q          <= fv_s;
      lv_q          <= lv_s;
    end
  end

`ifdef CAM_RESET_PULSE_EN
  logic [1:0] cam_rst_n_q, cam_rst_n_d;

  assign cam_rst_n_d[0] = !((state_d == S_CRST) && !cam_sel_d);
  assign cam_rst_n_d[1] = !((state_d == S_CRST) && cam_sel_d);

  // Active-low camera reset pulse register.
  always_ff @(posedge sysClk or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      cam_rst_n_q <= 2'b11;
    end else begin
      cam_rst_n_q <= cam_rst_n_d;
    end
  end

  assign reset_0 = cam_rst_n_q[0];
  assign reset_1 = cam_rst_n_q[1];
`else
  assign reset_0 = 1'b1;
  assign reset_1 = 1'b1;
`endif

  assign cmd_ready                  = cmd_ready_q;
  assign trigger_0                  = trigger_q[0];
  assign trigger_1                  = trigger_q[1];
  assign cam_sel                    = cam_sel_q;
  assign capture_active             = active_q;
  assign line_count                 = line_count_q;
  assign camera_id_error_flag       = id_err_q;
  assign camera_timeout_error_flag  = timeout_err_q;
  assign image_capture_failure_flag = fail_q;
  assign camera_not_detected_flag   = not_det_q;
  assign error_flag_valid           = efv_q;

endmodule

// File: tb/tb_camera_capture_sequencer.sv
// Directed plus randomized bench for camera_capture_sequencer (default build, no camera reset pulse).
module tb_camera_capture_sequencer;

  localparam int TRIG = 16;
  localparam int TO   = 100;

  logic        sysClk = 1'b0;
  logic        hard_reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_cam_id = 1'b0;
  logic [10:0] cmd_lines = 11'd0;
  logic [1:0]  cam_present = 2'b11;
  logic        fv_0 = 1'b0, fv_1 = 1'b0, lv_0 = 1'b0, lv_1 = 1'b0;
  logic        trigger_0, trigger_1, reset_0, reset_1, cam_sel, capture_active;
  logic [10:0] line_count;
  logic        id_err, to_err, fail_f, nd_f, efv;

  camera_capture_sequencer #(
    .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(24'd100), .RESET_CYCLES(64)
  ) dut (
    .sysClk(sysClk), .hard_reset_n(hard_reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_cam_id(cmd_cam_id),
    .cmd_lines(cmd_lines), .cam_present(cam_present),
    .fv_0(fv_0), .fv_1(fv_1), .lv_0(lv_0), .lv_1(lv_1),
    .trigger_0(trigger_0), .trigger_1(trigger_1), .reset_0(reset_0), .reset_1(reset_1),
    .cam_sel(cam_sel), .capture_active(capture_active), .line_count(line_count),
    .camera_id_error_flag(id_err), .camera_timeout_error_flag(to_err),
    .image_capture_failure_flag(fail_f), .camera_not_detected_flag(nd_f),
    .error_flag_valid(efv)
  );

  always #5 sysClk = ~sysClk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0_hi = 0, t1_hi = 0, t_rise = -1, t_fall = -1, efv_n = 0, efv_cyc = -1, rst_lo = 0;
  logic t0_prev = 1'b0, t1_prev = 1'b0;

  always @(posedge sysClk) cyc <= cyc + 1;

  // Observation of trigger pulses, report pulses and camera resets.
  always @(negedge sysClk) begin
    if (hard_reset_n) begin
      if (trigger_0) t0_hi <= t0_hi + 1;
      if (trigger_1) t1_hi <= t1_hi + 1;
      if ((trigger_0 && !t0_prev) || (trigger_1 && !t1_prev)) t_rise <= cyc;
      if ((!trigger_0 && t0_prev) || (!trigger_1 && t1_prev)) t_fall <= cyc;
      if (efv) begin
        efv_n   <= efv_n + 1;
        efv_cyc <= cyc;
      end
      if (!reset_0 || !reset_1) rst_lo <= rst_lo + 1;
      t0_prev <= trigger_0;
      t1_prev <= trigger_1;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sysClk);
  endtask

  task automatic set_fv(input bit cam, input logic v);
    if (cam) fv_1 = v; else fv_0 = v;
  endtask

  task automatic set_lv(input bit cam, input logic v);
    if (cam) lv_1 = v; else lv_0 = v;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, int'(cmd_ready), 1);
    chk({tag, "_trig0"}, int'(trigger_0), 0);
    chk({tag, "_trig1"}, int'(trigger_1), 0);
    chk({tag, "_rst0"}, int'(reset_0), 1);
    chk({tag, "_rst1"}, int'(reset_1), 1);
    chk({tag, "_sel"}, int'(cam_sel), 0);
    chk({tag, "_active"}, int'(capture_active), 0);
    chk({tag, "_lines"}, int'(line_count), 0);
    chk({tag, "_flags"}, int'({id_err, to_err, fail_f, nd_f}), 0);
    chk({tag, "_efv"}, int'(efv), 0);
  endtask

  // Complete frame: model says lines = min(pulses, 2047), failure iff lines differ from command.
  task automatic run_frame(input bit cam, input int lines, input int d, input int np,
                           input bit xt, input bit lvfall);
    int a, e, h0, h1, e0, exp_lines;
    h0 = t0_hi; h1 = t1_hi; e0 = efv_n;
    cmd_valid = 1'b1; cmd_cam_id = cam; cmd_lines = 11'(lines); a = cyc;
    tick(1);
    cmd_valid = 1'b0;
    chk("frame_active", int'(capture_active), 1);
    tick(TRIG + d);
    set_fv(cam, 1'b1);
    tick(1);
    for (int i = 0; i < np; i++) begin
      tick(int'($urandom_range(1, 3)));
      set_lv(cam, 1'b1);
      tick(int'($urandom_range(1, 3)));
      set_lv(cam, 1'b0);
    end
    if (xt) begin
      set_fv(!cam, 1'b1);
      tick(1);
      set_fv(!cam, 1'b0);
    end
    tick(1);
    set_fv(cam, 1'b0);
    if (lvfall) set_lv(cam, 1'b1);
    e = cyc;
    tick(1);
    set_lv(cam, 1'b0);
    tick(2);
    exp_lines = (np > 2047) ? 2047 : np;
    chk("frame_efv_count", efv_n - e0, 1);
    chk("frame_efv_cycle", efv_cyc, e + 1);
    chk("frame_trig_rise", t_rise, a + 1);
    chk("frame_trig_fall", t_fall, a + 1 + TRIG);
    chk("frame_trig_width", cam ? (t1_hi - h1) : (t0_hi - h0), TRIG);
    chk("frame_other_trig", cam ? (t0_hi - h0) : (t1_hi - h1), 0);
    chk("frame_lines", int'(line_count), exp_lines);
    chk("frame_sel", int'(cam_sel), int'(cam));
    chk("frame_id_err", int'(id_err), int'(xt));
    chk("frame_fail", int'(fail_f), (exp_lines != lines) ? 1 : 0);
    chk("frame_timeout", int'(to_err), 0);
    chk("frame_notdet", int'(nd_f), 0);
    chk("frame_ready", int'(cmd_ready), 1);
  endtask

  initial begin
    int a, w, e0, h0, h1;
    tick(3);
    chk_idle_outputs("reset");
    hard_reset_n = 1'b1;
    tick(2);

    // Directed frames: normal, short with cross-talk, lv edge on the fv falling edge.
    run_frame(1'b1, 4, 10, 4, 1'b0, 1'b0);
    run_frame(1'b1, 4, 3, 3, 1'b1, 1'b0);
    run_frame(1'b0, 2, 0, 2, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      run_frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 6)), int'($urandom_range(0, 40)),
                int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Absent camera, two commands back to back.
    for (int c = 0; c < 2; c++) begin
      cam_present = (c == 1) ? 2'b01 : 2'b10;
      e0 = efv_n; h0 = t0_hi; h1 = t1_hi;
      cmd_valid = 1'b1; cmd_cam_id = 1'(c); a = cyc;
      tick(1);
      chk("absent_ready_low", int'(cmd_ready), 0);
      chk("absent_efv", int'(efv), 1);
      chk("absent_notdet", int'(nd_f), 1);
      chk("absent_sel", int'(cam_sel), c);
      chk("absent_active", int'(capture_active), 0);
      tick(2);
      cmd_valid = 1'b0;
      tick(2);
      chk("absent_efv_count", efv_n - e0, 2);
      chk("absent_efv_cycle", efv_cyc, a + 3);
      chk("absent_no_trig", (t0_hi - h0) + (t1_hi - h1), 0);
    end
    cam_present = 2'b11;

    // Frame never starts.
    e0 = efv_n;
    cmd_valid = 1'b1; cmd_cam_id = 1'b0; a = cyc;
    tick(1);
    cmd_valid = 1'b0;
    tick(TRIG + TO + 3);
    chk("start_to_count", efv_n - e0, 1);
    chk("start_to_cycle", efv_cyc, a + 1 + TRIG + TO);
    chk("start_to_after_fall", efv_cyc - t_fall, TO);
    chk("start_to_flag", int'(to_err), 1);
    chk("start_to_fail", int'(fail_f), 0);
    chk("start_to_lines", int'(line_count), 0);

    // Frame never ends: capture timeout with matching line count.
    e0 = efv_n;
    cmd_valid = 1'b1; cmd_cam_id = 1'b1; cmd_lines = 11'd2;
    tick(1);
    cmd_valid = 1'b0;
    tick(TRIG + 5);
    fv_1 = 1'b1; w = cyc;
    for (int i = 0; i < 2; i++) begin
      tick(1); lv_1 = 1'b1; tick(1); lv_1 = 1'b0;
    end
    tick(w + 105 - cyc);
    fv_1 = 1'b0;
    tick(2);
    chk("cap_to_count", efv_n - e0, 1);
    chk("cap_to_cycle", efv_cyc, w + 101);
    chk("cap_to_fail", int'(fail_f), 1);
    chk("cap_to_flag", int'(to_err), 0);
    chk("cap_to_lines", int'(line_count), 2);

    // Hard reset in the middle of a capture.
    cmd_valid = 1'b1; cmd_cam_id = 1'b1; cmd_lines = 11'd3;
    tick(1);
    cmd_valid = 1'b0;
    tick(TRIG + 2);
    fv_1 = 1'b1;
    tick(2); lv_1 = 1'b1; tick(1); lv_1 = 1'b0; tick(3);
    chk("pre_reset_active", int'(capture_active), 1);
    hard_reset_n = 1'b0;
    #1;
    chk_idle_outputs("midreset");
    e0 = efv_n;
    fv_1 = 1'b0;
    tick(2);
    hard_reset_n = 1'b1;
    tick(5);
    chk("postreset_no_efv", efv_n - e0, 0);
    chk("postreset_ready", int'(cmd_ready), 1);
    chk("camera_reset_never_low", rst_lo, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
